wb4_sram_ctrl: RTL and testbench
================================

// Module: wb4_sram_ctrl
// PURPOSE
//  Pipelined WB4 slave that turns one WB4 access at a time into an asynchronous-SRAM cycle.
//  The wait states for reads and writes are programmable.
//  It sits directly downstream of the PI1Q-to-WB4 bridge, which drives its wb4_* inputs and consumes wb4_ack_o/wb4_data_o.
//  The bridge splits PIRWOP into a WB4 read followed by a WB4 write, so back-to-back accept on the ack cycle is mandatory.
// PARAMETERS
//  ARCHBITSZ      32  data width in bits (16/32/64); byte lanes = ARCHBITSZ/8
//  SRAMADDRBITSZ  18  SRAM word-address width
//  RDWAITCYCLES   2   cycles oe_n held low before read data is sampled (>=1)
//  WRWAITCYCLES   2   cycles we_n held low (>=1)
// PORTS
//  wb4_clk_i     in   1                 sole clock
//  wb4_rst_i     in   1                 asynchronous active-low reset
//  wb4_cyc_i     in   1                 WB4 cycle
//  wb4_stb_i     in   1                 WB4 strobe
//  wb4_we_i      in   1                 1=write
//  wb4_addr_i    in   ARCHBITSZ         byte address; low clog2(ARCHBITSZ/8) bits ignored (lanes come from sel)
//  wb4_data_i    in   ARCHBITSZ         write data
//  wb4_sel_i     in   ARCHBITSZ/8       byte enables
//  wb4_stall_o   out  1                 1=request not accepted this cycle
//  wb4_ack_o     out  1                 one-cycle completion pulse
//  wb4_data_o    out  ARCHBITSZ         read data, valid with ack on reads
//  sram_addr_o   out  SRAMADDRBITSZ     SRAM word address
//  sram_dq_o     out  ARCHBITSZ         SRAM write data
//  sram_dq_oe_o  out  1                 1=drive DQ (tristate at top level)
//  sram_dq_i     in   ARCHBITSZ         SRAM read data
//  sram_ce_n_o   out  1                 chip enable, active-low
//  sram_oe_n_o   out  1                 output enable, active-low
//  sram_we_n_o   out  1                 write enable, active-low
//  sram_be_n_o   out  ARCHBITSZ/8       byte enables, active-low (= ~sel)
// BEHAVIOUR
//  Reset (wb4_rst_i==0, async):
//   - state=IDLE; stall_o=0, ack_o=0, data_o=0, dq_oe_o=0.
//   - ce_n/oe_n/we_n=1; be_n all 1; addr_o=0, dq_o=0; wait counter=0.
//   - Reset mid-operation aborts immediately; the SRAM is deselected the same cycle.
//  Accept: in IDLE, stall_o=0; accept when cyc&stb.
//   - Latch addr[clog2+SRAMADDRBITSZ-1:clog2], data, sel and we.
//   - ce_n<=0. Excess address bits are truncated (wrap modulo 2^SRAMADDRBITSZ).
//  stall_o=1 in every state except IDLE; only one access is outstanding.
//  FSM:
//   - IDLE -> RD (we=0) or WR (we=1).
//   - RD: oe_n=0, count RDWAITCYCLES. On the last cycle, data_o<=sram_dq_i, ack_o<=1, -> IDLE (oe_n,ce_n<=1).
//   - WR: dq_oe_o=1, we_n=0, count WRWAITCYCLES; then -> WRHOLD.
//   - WRHOLD: we_n=1 with addr/dq/dq_oe held one cycle (hold time); ack_o<=1, -> IDLE; dq_oe_o,ce_n<=1.
//  Latency, accept to ack: read = RDWAITCYCLES+1 cycles; write = WRWAITCYCLES+2 cycles.
//  ack_o is registered and high for exactly 1 cycle. That cycle is IDLE (stall_o=0), so a new request may be accepted on it.
//  data_o holds its last read value until the next read completes (0 on writes is not required).
//  cyc_i dropped mid-access:
//   - The SRAM cycle completes so a write is never truncated, but ack_o is suppressed.
//   - The state returns to IDLE normally.
//  sel_i==0: full SRAM cycle with all be_n=1; ack still returned.
//  oe_n and we_n are never both low; dq_oe_o is never 1 while oe_n=0.
// CONFIGURATION
//  WB4_SRAM_CTRL_RDBUF_EN defined: one-entry read buffer (tag + valid + data).
//   - A read whose word address matches the valid tag is answered from the buffer with ack next cycle.
//   - The hit skips the SRAM cycle and leaves ce_n=1.
//   - Any accepted write to the same word updates the buffered bytes per sel; valid stays set.
//   - Reset clears valid.
//  Not defined: every read goes to the SRAM; no buffer flops exist.
// STRUCTURE
//  Shared package (lib/perint include): FSM state localparams IDLE/RD/WR/WRHOLD, and a clog2 helper for ARCHBITSZ/8.
//  Sub-module wb4_sram_rdbuf: buffer tag/valid/data, hit compare and byte-merge on write.
//   - Instantiated only under WB4_SRAM_CTRL_RDBUF_EN.
//  The wait counter is inline and sized clog2(max(RDWAITCYCLES,WRWAITCYCLES)+1).
// TESTING
//  1 Reset: drive rst low mid-WR (we_n=0) -> same cycle: we_n=1, ce_n=1, dq_oe=0, ack=0, stall=0.
//  2 Write addr=0x10 data=0xDEADBEEF sel=4'hF, WRWAITCYCLES=2:
//    -> sram_addr=0x4; we_n low 2 cycles; ack at accept+4; be_n=0.
//  3 Read 0x10 (RDWAITCYCLES=2, sram_dq_i=0xDEADBEEF) -> ack at accept+3, wb4_data_o=0xDEADBEEF.
//  4 Read then write, the write stb asserted on the read ack cycle:
//    -> write accepted that cycle (stall=0); oe_n/we_n never both low.
//  5 Write sel=4'b0100 data=0x00AA0000 -> be_n=4'b1011; drop cyc after accept -> we_n pulse completes, no ack.
//  6 RDBUF_EN: read 0x20 twice -> 2nd ack 1 cycle after accept, ce_n stays 1.
//    Then write sel=4'b0001 0x55 to 0x20 and read -> data low byte 0x55 from the buffer.

Source files
------------

// File: rtl/wb4_sram_ctrl_pkg.sv
// Shared FSM encoding and width helper for the WB4 asynchronous-SRAM controller.
package wb4_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD     = 2'd1,
    WR     = 2'd2,
    WRHOLD = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb4_sram_rdbuf.sv
// One-entry read buffer: word tag, valid bit and data, kept coherent with writes to the same word.
module wb4_sram_rdbuf import wb4_sram_ctrl_pkg::*; #(
  parameter int ARCHBITSZ     = 32,
  parameter int SRAMADDRBITSZ = 18
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [SRAMADDRBITSZ-1:0] lookup_addr_i,
  output logic                     hit_o,
  output logic [ARCHBITSZ-1:0]     data_o,
  input  logic                     fill_i,
  input  logic [SRAMADDRBITSZ-1:0] fill_addr_i,
  input  logic [ARCHBITSZ-1:0]     fill_data_i,
  input  logic                     wr_i,
  input  logic [SRAMADDRBITSZ-1:0] wr_addr_i,
  input  logic [ARCHBITSZ-1:0]     wr_data_i,
  input  logic [ARCHBITSZ/8-1:0]   wr_sel_i
);

  localparam int LANES = ARCHBITSZ / 8;

  logic                     valid_q, valid_d;
  logic [SRAMADDRBITSZ-1:0] tag_q, tag_d;
  logic [ARCHBITSZ-1:0]     data_q, data_d;

  assign hit_o  = valid_q && (tag_q == lookup_addr_i);
  assign data_o = data_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = fill_addr_i;
      data_d  = fill_data_i;
    end else if (wr_i && valid_q && (wr_addr_i == tag_q)) begin
      for (int b = 0; b < LANES; b++) begin
        if (wr_sel_i[b]) data_d[8*b +: 8] = wr_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/wb4_sram_ctrl.sv
// Pipelined WB4 slave driving an asynchronous SRAM, one access at a time, programmable wait states.
// Define WB4_SRAM_CTRL_RDBUF_EN to add a one-entry read buffer that answers repeat reads without an SRAM cycle.
module wb4_sram_ctrl import wb4_sram_ctrl_pkg::*; #(
  parameter int ARCHBITSZ     = 32,
  parameter int SRAMADDRBITSZ = 18,
  parameter int RDWAITCYCLES  = 2,
  parameter int WRWAITCYCLES  = 2
) (
  input  logic                     wb4_clk_i,
  input  logic                     wb4_rst_i,
  input  logic                     wb4_cyc_i,
  input  logic                     wb4_stb_i,
  input  logic                     wb4_we_i,
  input  logic [ARCHBITSZ-1:0]     wb4_addr_i,
  input  logic [ARCHBITSZ-1:0]     wb4_data_i,
  input  logic [ARCHBITSZ/8-1:0]   wb4_sel_i,
  output logic                     wb4_stall_o,
  output logic                     wb4_ack_o,
  output logic [ARCHBITSZ-1:0]     wb4_data_o,
  output logic [SRAMADDRBITSZ-1:0] sram_addr_o,
  output logic [ARCHBITSZ-1:0]     sram_dq_o,
  output logic                     sram_dq_oe_o,
  input  logic [ARCHBITSZ-1:0]     sram_dq_i,
  output logic                     sram_ce_n_o,
  output logic                     sram_oe_n_o,
  output logic                     sram_we_n_o,
  output logic [ARCHBITSZ/8-1:0]   sram_be_n_o
);

  localparam int LANES = ARCHBITSZ / 8;
  localparam int LSB   = clog2(LANES);
  localparam int MAXWC = (RDWAITCYCLES > WRWAITCYCLES) ? RDWAITCYCLES : WRWAITCYCLES;
  localparam int CNTW  = clog2(MAXWC + 1);

  state_e                   state_q, state_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic                     ack_q, ack_d;
  logic [ARCHBITSZ-1:0]     data_q, data_d;
  logic [SRAMADDRBITSZ-1:0] addr_q, addr_d;
  logic [ARCHBITSZ-1:0]     dq_q, dq_d;
  logic                     dq_oe_q, dq_oe_d;
  logic                     ce_n_q, ce_n_d;
  logic                     oe_n_q, oe_n_d;
  logic                     we_n_q, we_n_d;
  logic [LANES-1:0]         be_n_q, be_n_d;
  logic                     abort_q, abort_d;

  logic                     accept;
  logic                     rd_last;
  logic                     wr_last;
  logic [SRAMADDRBITSZ-1:0] req_word;
  logic                     buf_hit;
  logic [ARCHBITSZ-1:0]     buf_data;
  logic                     unused_addr;

  // Word address wraps modulo the SRAM size; byte-lane bits come from sel instead.
  assign req_word    = wb4_addr_i[LSB +: SRAMADDRBITSZ];
  assign unused_addr = ^wb4_addr_i;

  assign accept  = (state_q == IDLE) && wb4_cyc_i && wb4_stb_i;
  assign rd_last = (state_q == RD) && (cnt_q == CNTW'(RDWAITCYCLES - 1));
  assign wr_last = (state_q == WR) && (cnt_q == CNTW'(WRWAITCYCLES - 1));

`ifdef WB4_SRAM_CTRL_RDBUF_EN
  logic rdbuf_hit;

  wb4_sram_rdbuf #(
    .ARCHBITSZ     (ARCHBITSZ),
    .SRAMADDRBITSZ (SRAMADDRBITSZ)
  ) u_rdbuf (
    .clk_i         (wb4_clk_i),
    .rst_ni        (wb4_rst_i),
    .lookup_addr_i (req_word),
    .hit_o         (rdbuf_hit),
    .data_o        (buf_data),
    .fill_i        (rd_last),
    .fill_addr_i   (addr_q),
    .fill_data_i   (sram_dq_i),
    .wr_i          (accept && wb4_we_i),
    .wr_addr_i     (req_word),
    .wr_data_i     (wb4_data_i),
    .wr_sel_i      (wb4_sel_i)
  );

  assign buf_hit = accept && !wb4_we_i && rdbuf_hit;
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_ff @(posedge wb4_clk_i or negedge wb4_rst_i) begin
    if (!wb4_rst_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !buf_hit) state_d = wb4_we_i ? WR : RD;
      RD:      if (rd_last) state_d = IDLE;
      WR:      if (wr_last) state_d = WRHOLD;
      WRHOLD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered so the SRAM pins never see decode glitches.
  always_comb begin
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    data_d  = data_q;
    addr_d  = addr_q;
    dq_d    = dq_q;
    dq_oe_d = dq_oe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    be_n_d  = be_n_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        if (buf_hit) begin
          ack_d  = 1'b1;
          data_d = buf_data;
        end else if (accept) begin
          addr_d  = req_word;
          be_n_d  = ~wb4_sel_i;
          cnt_d   = '0;
          ce_n_d  = 1'b0;
          abort_d = 1'b0;
          if (wb4_we_i) begin
            dq_d    = wb4_data_i;
            dq_oe_d = 1'b1;
            we_n_d  = 1'b0;
          end else begin
            oe_n_d  = 1'b0;
          end
        end
      end
      RD: begin
        if (!wb4_cyc_i) abort_d = 1'b1;
        if (rd_last) begin
          data_d = sram_dq_i;
          ack_d  = wb4_cyc_i && !abort_q;
          oe_n_d = 1'b1;
          ce_n_d = 1'b1;
          be_n_d = '1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      WR: begin
        if (!wb4_cyc_i) abort_d = 1'b1;
        if (wr_last) we_n_d = 1'b1;
        else         cnt_d  = cnt_q + CNTW'(1);
      end
      WRHOLD: begin
        ack_d   = wb4_cyc_i && !abort_q;
        dq_oe_d = 1'b0;
        ce_n_d  = 1'b1;
        be_n_d  = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb4_clk_i or negedge wb4_rst_i) begin
    if (!wb4_rst_i) begin
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= '1;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      abort_q <= abort_d;
    end
  end

  assign wb4_stall_o  = (state_q != IDLE);
  assign wb4_ack_o    = ack_q;
  assign wb4_data_o   = data_q;
  assign sram_addr_o  = addr_q;
  assign sram_dq_o    = dq_q;
  assign sram_dq_oe_o = dq_oe_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_be_n_o  = be_n_q;

endmodule

// File: tb/tb_wb4_sram_ctrl.sv
// Scoreboard bench for wb4_sram_ctrl: random WB4 traffic against a word-array model plus SRAM pin checks.
module tb_wb4_sram_ctrl;

  localparam int AW  = 32;
  localparam int SAW = 18;
  localparam int RDW = 2;
  localparam int WRW = 2;
  localparam int LN  = AW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0, wdata = '0;
  logic [LN-1:0] sel = '0;

  logic stall, ack, sdq_oe, ce_n, oe_n, we_n;
  logic [AW-1:0] rdata, sdq_o, sdq_i;
  logic [SAW-1:0] saddr;
  logic [LN-1:0] be_n;

  always #5 clk = ~clk;

  wb4_sram_ctrl #(
    .ARCHBITSZ(AW), .SRAMADDRBITSZ(SAW), .RDWAITCYCLES(RDW), .WRWAITCYCLES(WRW)
  ) dut (
    .wb4_clk_i(clk), .wb4_rst_i(rst_n), .wb4_cyc_i(cyc), .wb4_stb_i(stb),
    .wb4_we_i(we), .wb4_addr_i(addr), .wb4_data_i(wdata), .wb4_sel_i(sel),
    .wb4_stall_o(stall), .wb4_ack_o(ack), .wb4_data_o(rdata),
    .sram_addr_o(saddr), .sram_dq_o(sdq_o), .sram_dq_oe_o(sdq_oe), .sram_dq_i(sdq_i),
    .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n), .sram_be_n_o(be_n)
  );

  // SRAM device seen by the DUT pins
  bit [AW-1:0] sram [0:(1<<SAW)-1];
  always @(posedge clk)
    if (!ce_n && !we_n && sdq_oe)
      for (int b = 0; b < LN; b++)
        if (!be_n[b]) sram[saddr][8*b +: 8] <= sdq_o[8*b +: 8];
  assign sdq_i = (!ce_n && !oe_n) ? sram[saddr] : '0;

  // Reference: the memory as the bus master expects it to be
  bit [AW-1:0] ref_mem [0:(1<<SAW)-1];
`ifdef WB4_SRAM_CTRL_RDBUF_EN
  bit buf_valid = 1'b0;
  int buf_word  = 0;
`endif

  typedef struct {
    bit          we;
    logic [AW-1:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0, checks = 0;
  int cyc_cnt = 0, acks_seen = 0, last_acc = 0;
  int we_run = 0, last_we_run = 0, ce_low = 0;
  logic [SAW-1:0] last_we_addr = '0;
  logic [LN-1:0]  last_we_be = '0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: ack scoreboard, pin protocol and write-pulse capture
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((!oe_n && !we_n) || (sdq_oe && !oe_n)) begin
        errors++;
        $display("FAIL pin_conflict: oe_n=%0b we_n=%0b dq_oe=%0b", oe_n, we_n, sdq_oe);
      end
      if (ack) begin
        exp_t e;
        acks_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: got ack at cycle %0d, expected none", cyc_cnt);
        end else begin
          e = exp_q.pop_front();
          if (cyc_cnt != e.cyc) begin
            errors++;
            $display("FAIL ack_cycle: got %0d expected %0d", cyc_cnt, e.cyc);
          end
          if (!e.we) begin
            checks++;
            if (rdata !== e.data) begin
              errors++;
              $display("FAIL read_data: got %h expected %h", rdata, e.data);
            end
          end
        end
      end
      if (!we_n) begin
        we_run++;
        last_we_addr = saddr;
        last_we_be   = be_n;
      end else if (we_run != 0) begin
        last_we_run = we_run;
        we_run = 0;
      end
      if (!ce_n) ce_low++;
    end
  end

  // Called on a negedge; returns on the negedge after acceptance with stb low.
  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [AW-1:0] d,
                       input logic [LN-1:0] s, input bit want_ack);
    int n, word, lat;
    exp_t e;
    n = 0;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    while (stall && n < 64) begin @(negedge clk); n++; end
    checks++;
    if (stall) begin
      errors++;
      $display("FAIL accept_timeout: stall=%0b after %0d cycles, expected 0", stall, n);
    end
    last_acc = cyc_cnt;
    word = int'((a >> 2) & ((1 << SAW) - 1));
    if (w) begin
      for (int b = 0; b < LN; b++)
        if (s[b]) ref_mem[word][8*b +: 8] = d[8*b +: 8];
      lat = WRW + 2;
    end else begin
      lat = RDW + 1;
`ifdef WB4_SRAM_CTRL_RDBUF_EN
      if (buf_valid && buf_word == word) lat = 1;
      else begin buf_valid = 1'b1; buf_word = word; end
`endif
    end
    e.we = w; e.data = ref_mem[word]; e.cyc = last_acc + lat;
    if (want_ack) exp_q.push_back(e);
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || stall) && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0 || stall) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d stall=%0b, expected 0 and 0", exp_q.size(), stall);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_acc, wr_acc, acks0, ce0;
    bit w;
    logic [AW-1:0] a;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_ack",   64'(ack), 64'd0);
    chk("rst_data",  64'(rdata), 64'd0);
    chk("rst_ctrl",  64'({ce_n, oe_n, we_n, sdq_oe}), 64'b1110);
    chk("rst_be_n",  64'(be_n), 64'hF);
    chk("rst_addr",  64'(saddr), 64'd0);
    chk("rst_dq",    64'(sdq_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-word write then read back
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
    drain();
    chk("wr_we_pulse", 64'(last_we_run), 64'(WRW));
    chk("wr_sram_addr", 64'(last_we_addr), 64'h4);
    chk("wr_be_n", 64'(last_we_be), 64'h0);
    issue(1'b0, 32'h10, '0, 4'hF, 1'b1);
    drain();
    chk("rd_deadbeef", 64'(rdata), 64'hDEADBEEF);

    // Write request held so it lands on the read's ack cycle
    issue(1'b0, 32'h14, '0, 4'hF, 1'b1);
    rd_acc = last_acc;
    issue(1'b1, 32'h18, 32'h12345678, 4'hF, 1'b1);
    wr_acc = last_acc;
    chk("b2b_accept_cycle", 64'(wr_acc), 64'(rd_acc + RDW + 1));
    drain();

    // Single-lane write with cyc dropped: pulse completes, no ack
    acks0 = acks_seen;
    issue(1'b1, 32'h24, 32'h00AA0000, 4'b0100, 1'b0);
    cyc = 1'b0;
    drain();
    cyc = 1'b1;
    chk("abort_no_ack", 64'(acks_seen), 64'(acks0));
    chk("abort_we_pulse", 64'(last_we_run), 64'(WRW));
    chk("abort_be_n", 64'(last_we_be), 64'b1011);
    issue(1'b0, 32'h24, '0, 4'hF, 1'b1);
    drain();
    chk("abort_write_landed", 64'(rdata[23:16]), 64'hAA);

    // Repeat reads and a partial write to the same word
    issue(1'b0, 32'h20, '0, 4'hF, 1'b1);
    drain();
    ce0 = ce_low;
    issue(1'b0, 32'h20, '0, 4'hF, 1'b1);
    drain();
`ifdef WB4_SRAM_CTRL_RDBUF_EN
    chk("hit_no_ce", 64'(ce_low), 64'(ce0));
`endif
    issue(1'b1, 32'h20, 32'h00000055, 4'b0001, 1'b1);
    drain();
    ce0 = ce_low;
    issue(1'b0, 32'h20, '0, 4'hF, 1'b1);
    drain();
    chk("merge_low_byte", 64'(rdata[7:0]), 64'h55);
`ifdef WB4_SRAM_CTRL_RDBUF_EN
    chk("merge_hit_no_ce", 64'(ce_low), 64'(ce0));
`endif

    // Random traffic over a small word set with wrapped high address bits
    for (int i = 0; i < 300; i++) begin
      w = ($urandom_range(0, 9) < 4);
      a = ($urandom & 32'hFFF0_0000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      issue(w, a, $urandom, 4'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Asynchronous reset while we_n is low
    issue(1'b1, 32'h000FFFC0, 32'hCAFEF00D, 4'hF, 1'b0);
    chk("mid_wr_we_n_low", 64'(we_n), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we_n", 64'(we_n), 64'd1);
    chk("arst_ce_n", 64'(ce_n), 64'd1);
    chk("arst_dq_oe", 64'(sdq_oe), 64'd0);
    chk("arst_ack", 64'(ack), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    exp_q.delete();
`ifdef WB4_SRAM_CTRL_RDBUF_EN
    buf_valid = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'h20, '0, 4'hF, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
